// File: rtl/lcd_write_ctrl.sv
// HD44780-style write controller: turns a strobe edge on the core LCD
// register into a timed RS/DATA setup, EN pulse, hold and execution wait,
// with a one-entry pending buffer and a sticky overflow flag.
module lcd_write_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] lcd_word_i,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o,
  output logic        busy_o,
  output logic        ovf_o
);

  localparam int CNT_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_EXEC  = 3'd4;

  // Counter reload values: each state runs until the counter reaches zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [8:0]       pend_word_reg, pend_word_next;
  logic [8:0]       bus_reg, bus_next;      // {rs, data[7:0]}
  logic             ovf_reg, ovf_next;
  logic             strobe_prev_reg;
  logic             lcd_on_reg;

  logic       req;
  logic [8:0] req_word;
  logic       cnt_done;
  logic       last_exec;
  logic       unused_bits;

  assign req       = lcd_word_i[10] & ~strobe_prev_reg;
  assign req_word  = {lcd_word_i[9], lcd_word_i[7:0]};
  assign cnt_done  = (cnt_reg == '0);
  assign last_exec = (state_reg == ST_EXEC) && cnt_done;

  // Bits of the core register this block does not use.
  assign unused_bits = ^{lcd_word_i[30:11], lcd_word_i[8]};

  // Strobe edge history and display-on mirror; resets with strobe seen high
  // so a strobe held across reset release must go low before it counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strobe_prev_reg <= 1'b1;
      lcd_on_reg      <= 1'b0;
    end else begin
      strobe_prev_reg <= lcd_word_i[10];
      lcd_on_reg      <= lcd_word_i[31];
    end
  end

  // Next-state logic: transfer sequencing, pending buffer and overflow.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    pend_valid_next = pend_valid_reg;
    pend_word_next  = pend_word_reg;
    bus_next        = bus_reg;
    ovf_next        = ovf_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_SETUP;
          cnt_next   = SETUP_LD;
          bus_next   = req_word;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_next = ST_PULSE;
          cnt_next   = PULSE_LD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_done) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_next = ST_EXEC;
          cnt_next   = EXEC_LD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_EXEC: begin
        if (cnt_done) begin
          if (pend_valid_reg) begin
            // Pending entry launches; a same-cycle request takes its slot.
            state_next      = ST_SETUP;
            cnt_next        = SETUP_LD;
            bus_next        = pend_word_reg;
            pend_valid_next = req;
            if (req) begin
              pend_word_next = req_word;
            end
          end else if (req) begin
            state_next = ST_SETUP;
            cnt_next   = SETUP_LD;
            bus_next   = req_word;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    // Requests arriving mid-transfer queue once, then are dropped.
    if (req && (state_reg != ST_IDLE) && !last_exec) begin
      if (!pend_valid_reg) begin
        pend_valid_next = 1'b1;
        pend_word_next  = req_word;
      end else begin
        ovf_next = 1'b1;
      end
    end
  end

  // FSM, counter, pending buffer, bus and overflow registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      pend_valid_reg <= 1'b0;
      pend_word_reg  <= '0;
      bus_reg        <= '0;
      ovf_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_word_reg  <= pend_word_next;
      bus_reg        <= bus_next;
      ovf_reg        <= ovf_next;
    end
  end

  assign lcd_on_o   = lcd_on_reg;
  assign lcd_rs_o   = bus_reg[8];
  assign lcd_data_o = bus_reg[7:0];
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = (state_reg == ST_PULSE);
  assign busy_o     = (state_reg != ST_IDLE) | pend_valid_reg;
  assign ovf_o      = ovf_reg;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Self-checking bench for lcd_write_ctrl: a transfer-offset model checked
// every cycle, directed scenarios with literal timing expectations, then
// randomized strobe/data/reset traffic.
module tb_lcd_write_ctrl;

  localparam int S    = 2;
  localparam int P    = 4;
  localparam int H    = 2;
  localparam int E    = 10;
  localparam int T    = S + P + H + E;
  localparam int LOGN = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lcd_word;
  logic        lcd_on, lcd_rs, lcd_rw, lcd_en, busy, ovf;
  logic [7:0]  lcd_data;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Behavioural model: a transfer is "active" with offset m_t in 0..T-1.
  bit       m_active = 1'b0;
  int       m_t      = 0;
  bit       m_pend   = 1'b0;
  bit [8:0] m_pend_word = '0;
  bit [8:0] m_bus    = '0;
  bit       m_ovf    = 1'b0;
  bit       m_prev   = 1'b1;
  bit       m_on     = 1'b0;

  logic       en_log   [LOGN];
  logic       busy_log [LOGN];
  logic       ovf_log  [LOGN];
  logic [8:0] bus_log  [LOGN];

  lcd_write_ctrl #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .EXEC_CYC(E)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .lcd_word_i(lcd_word),
    .lcd_on_o  (lcd_on),
    .lcd_rs_o  (lcd_rs),
    .lcd_rw_o  (lcd_rw),
    .lcd_en_o  (lcd_en),
    .lcd_data_o(lcd_data),
    .busy_o    (busy),
    .ovf_o     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_t = 0; m_pend = 1'b0; m_pend_word = '0;
    m_bus = '0; m_ovf = 1'b0; m_prev = 1'b1; m_on = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] w);
    bit       rq;
    bit [8:0] nw;
    rq     = w[10] && !m_prev;
    nw     = {w[9], w[7:0]};
    m_prev = w[10];
    m_on   = w[31];
    if (!m_active) begin
      if (rq) begin m_active = 1'b1; m_t = 0; m_bus = nw; end
    end else if (m_t == T - 1) begin
      if (m_pend) begin
        m_bus = m_pend_word; m_t = 0; m_pend = rq;
        if (rq) m_pend_word = nw;
      end else if (rq) begin
        m_bus = nw; m_t = 0;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_t++;
      if (rq) begin
        if (!m_pend) begin m_pend = 1'b1; m_pend_word = nw; end
        else m_ovf = 1'b1;
      end
    end
  endtask

  // Per-cycle compare of every output against the model, plus trace logging.
  always begin
    bit exp_en;
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_step(lcd_word);
    #1;
    exp_en = m_active && (m_t >= S) && (m_t < S + P);
    chk("en",   32'(lcd_en),   32'(exp_en));
    chk("busy", 32'(busy),     32'(m_active || m_pend));
    chk("ovf",  32'(ovf),      32'(m_ovf));
    chk("rs",   32'(lcd_rs),   32'(m_bus[8]));
    chk("data", 32'(lcd_data), 32'(m_bus[7:0]));
    chk("on",   32'(lcd_on),   32'(m_on));
    chk("rw",   32'(lcd_rw),   32'd0);
    en_log[cyc % LOGN]   = lcd_en;
    busy_log[cyc % LOGN] = busy;
    ovf_log[cyc % LOGN]  = ovf;
    bus_log[cyc % LOGN]  = {lcd_rs, lcd_data};
  end

  function automatic int cnt_en(input int from, input int n);
    int c = 0;
    for (int i = from; i < from + n; i++) c += en_log[i % LOGN] ? 1 : 0;
    return c;
  endfunction

  function automatic int cnt_busy(input int from, input int n);
    int c = 0;
    for (int i = from; i < from + n; i++) c += busy_log[i % LOGN] ? 1 : 0;
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // One strobe edge carrying word w; a0 is the first SETUP cycle index.
  task automatic pulse(input logic [31:0] w, output int a0);
    lcd_word = w | 32'h400;
    tick(1);
    a0 = cyc;
    lcd_word = w & ~32'h400;
    $display("write rs=%0d data=0x%02h edge at cycle %0d", w[9], w[7:0], a0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_en",   32'(lcd_en),   32'd0);
    chk("rst_data", 32'(lcd_data), 32'd0);
    chk("rst_rs",   32'(lcd_rs),   32'd0);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_ovf",  32'(ovf),      32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int a0, a1, a2;
    bit strobe;
    int rate;
    logic [31:0] w;

    rst_n    = 1'b0;
    lcd_word = 32'h0;
    tick(3);
    chk("init_en",   32'(lcd_en),   32'd0);
    chk("init_busy", 32'(busy),     32'd0);
    chk("init_on",   32'(lcd_on),   32'd0);
    chk("init_data", 32'(lcd_data), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Display-on follows bit31 one cycle later; no transfer.
    lcd_word = 32'h8000_0000;
    tick(1);
    chk("on_set", 32'(lcd_on), 32'd1);
    chk("on_en",  32'(lcd_en), 32'd0);
    lcd_word = 32'h0000_03FF;  // data/rs churn without strobe
    tick(1);
    chk("on_clr", 32'(lcd_on), 32'd0);
    tick(3);
    chk("nostrobe_busy", 32'(busy), 32'd0);
    lcd_word = 32'h0;
    tick(2);

    // Single write.
    pulse(32'h641, a0);
    tick(25);
    chk("sw_busy_cnt", 32'(cnt_busy(a0, 25)), 32'd18);
    chk("sw_busy_pre", 32'(busy_log[(a0 - 1) % LOGN]), 32'd0);
    chk("sw_busy_end", 32'(busy_log[(a0 + 17) % LOGN]), 32'd1);
    chk("sw_busy_off", 32'(busy_log[(a0 + 18) % LOGN]), 32'd0);
    chk("sw_en_cnt",   32'(cnt_en(a0, 25)), 32'd4);
    chk("sw_en_pre",   32'(en_log[(a0 + 1) % LOGN]), 32'd0);
    chk("sw_en_first", 32'(en_log[(a0 + 2) % LOGN]), 32'd1);
    chk("sw_en_after", 32'(en_log[(a0 + 6) % LOGN]), 32'd0);
    chk("sw_bus_0",    32'(bus_log[a0 % LOGN]), 32'h141);
    chk("sw_bus_7",    32'(bus_log[(a0 + 7) % LOGN]), 32'h141);

    // Back-to-back: second edge during PULSE.
    pulse(32'h641, a0);
    tick(2);
    pulse(32'h642, a1);
    tick(40);
    chk("bb_en_cnt",   32'(cnt_en(a0, 40)), 32'd8);
    chk("bb_busy_cnt", 32'(cnt_busy(a0, 40)), 32'd36);
    chk("bb_bus2",     32'(bus_log[(a0 + 18) % LOGN]), 32'h142);
    chk("bb_en2",      32'(en_log[(a0 + 20) % LOGN]), 32'd1);
    chk("bb_ovf",      32'(ovf), 32'd0);

    // Overflow: three edges inside the first transfer.
    pulse(32'h641, a0);
    tick(2);
    pulse(32'h642, a1);
    tick(2);
    pulse(32'h643, a2);
    tick(40);
    chk("ov_pre",     32'(ovf_log[(a2 - 1) % LOGN]), 32'd0);
    chk("ov_set",     32'(ovf_log[a2 % LOGN]), 32'd1);
    chk("ov_en_cnt",  32'(cnt_en(a0, 40)), 32'd8);
    chk("ov_bus2",    32'(bus_log[(a0 + 18) % LOGN]), 32'h142);
    chk("ov_no3",     32'(busy_log[(a0 + 36) % LOGN]), 32'd0);
    chk("ov_sticky",  32'(ovf), 32'd1);
    do_reset();
    tick(2);

    // Edge in the last EXEC cycle with pending full.
    pulse(32'h641, a0);
    tick(2);
    pulse(32'h642, a1);
    tick(14);
    pulse(32'h643, a2);
    tick(60);
    chk("le_en_cnt",   32'(cnt_en(a0, 60)), 32'd12);
    chk("le_busy_cnt", 32'(cnt_busy(a0, 60)), 32'd54);
    chk("le_bus2",     32'(bus_log[(a0 + 18) % LOGN]), 32'h142);
    chk("le_bus3",     32'(bus_log[(a0 + 36) % LOGN]), 32'h143);
    chk("le_ovf",      32'(ovf), 32'd0);

    // Edge in the last EXEC cycle with pending empty launches directly.
    pulse(32'h641, a0);
    tick(17);
    pulse(32'h644, a1);
    tick(40);
    chk("ld_bus",      32'(bus_log[(a0 + 18) % LOGN]), 32'h144);
    chk("ld_en",       32'(en_log[(a0 + 20) % LOGN]), 32'd1);
    chk("ld_busy_cnt", 32'(cnt_busy(a0, 40)), 32'd36);

    // Reset mid-PULSE with strobe held high across release.
    lcd_word = 32'h641;
    tick(1);
    a0 = cyc;
    tick(3);
    chk("rp_en_mid", 32'(lcd_en), 32'd1);
    do_reset();
    tick(8);
    chk("rp_busy_held", 32'(cnt_busy(cyc - 7, 8)), 32'd0);
    lcd_word = 32'h241;
    tick(1);
    chk("rp_busy_low", 32'(busy), 32'd0);
    lcd_word = 32'h641;
    tick(1);
    chk("rp_busy_edge", 32'(busy), 32'd1);
    chk("rp_data_edge", 32'(lcd_data), 32'h41);
    lcd_word = 32'h0;
    tick(25);

    // Randomized traffic with occasional resets.
    strobe = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      rate = ((i / 500) % 2 != 0) ? 2 : 9;
      if ($urandom_range(0, rate) == 0) strobe = ~strobe;
      w     = $urandom;
      w[10] = strobe;
      lcd_word = w;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      tick(1);
    end
    rst_n    = 1'b1;
    lcd_word = 32'h0;
    tick(30);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_write_ctrl.md
LCD_WRITE_CTRL -- requirements
Module: lcd_write_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles RS/DATA are stable before EN rises (>=1).
REQ-002 Parameter PULSE_CYC, default 12: cycles EN is held high (>=1).
REQ-003 Parameter HOLD_CYC, default 2: cycles RS/DATA stay stable after EN falls (>=1).
REQ-004 Parameter EXEC_CYC, default 2000: cycles of LCD execution wait after HOLD (>=1).
REQ-005 Ports, one per line:
- clk_i input 1: single clock.
- rst_ni input 1: reset, asynchronous, active-low.
- lcd_word_i input 32: core LCD I/O register. [31]=display on, [10]=write strobe, [9]=RS, [7:0]=data; other bits ignored.
- lcd_on_o output 1: display power/backlight enable.
- lcd_rs_o output 1: HD44780 register select.
- lcd_rw_o output 1: read/write select, always 0 (write only).
- lcd_en_o output 1: HD44780 enable strobe.
- lcd_data_o output 8: HD44780 data bus.
- busy_o output 1: transfer in progress or pending.
- ovf_o output 1: sticky, a request was dropped.

Function
REQ-006 The block SHALL register lcd_word_i[31] onto lcd_on_o with 1-cycle latency, independent of the FSM.
REQ-007 A request SHALL be a rising edge of lcd_word_i[10]: sampled value 1 while the previous sampled value is 0; the previous-value register resets to 1.
REQ-008 On each request the block SHALL capture {lcd_word_i[9], lcd_word_i[7:0]} in the cycle the edge is detected.
REQ-009 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, EXEC; one down-counter of at least 16 bits times each state.
REQ-010 IDLE -> SETUP on a request; lcd_rs_o/lcd_data_o take the captured values on SETUP entry, 1 cycle after the edge cycle.
REQ-011 SETUP lasts SETUP_CYC cycles, then PULSE; lcd_en_o SHALL be 1 for exactly the PULSE_CYC PULSE cycles and 0 in every other state.
REQ-012 PULSE -> HOLD (HOLD_CYC cycles) -> EXEC (EXEC_CYC cycles); lcd_rs_o/lcd_data_o SHALL remain unchanged from SETUP entry through the last HOLD cycle.
REQ-013 At the end of EXEC the FSM SHALL go to SETUP with the pending entry if it is valid, else to IDLE.
REQ-014 A request while the state is not IDLE SHALL be stored in a single-entry pending buffer if it is empty.
REQ-015 A request while the pending buffer is full SHALL be dropped and SHALL set ovf_o, which stays 1 until reset.
REQ-016 A request in the last EXEC cycle with the pending buffer full SHALL be accepted: the pending entry launches and the new request refills the pending buffer; ovf_o is not set.
REQ-017 A request in the last EXEC cycle with the pending buffer empty SHALL launch directly into SETUP the next cycle.
REQ-018 busy_o SHALL be 1 whenever the state is not IDLE or the pending buffer is valid, and 0 in IDLE.
REQ-019 Changes to lcd_word_i[9:0] without a strobe rising edge SHALL NOT affect the bus or the FSM.

Reset
REQ-020 Asserting rst_ni low at any time, including mid-transfer, SHALL immediately force IDLE, clear the pending buffer and counter, drive every output to 0, and clear ovf_o.
REQ-021 After rst_ni rises, a strobe already high SHALL NOT generate a request until it has been sampled low.

Verification
REQ-022 Use SETUP=2, PULSE=4, HOLD=2, EXEC=10 for the following scenarios.
- Single write: word 0x0000_0641 (strobe, RS=1, data 0x41) -> SETUP starts the cycle after the edge; EN high for 4 cycles starting 2 cycles later; rs=1, data=0x41 stable for 8 cycles; busy_o=1 for 18 cycles, then 0.
- Back-to-back: second edge (data 0x42) during PULSE of the first -> the second SETUP begins the cycle after the first EXEC ends; ovf_o=0.
- Overflow: three edges (0x41, 0x42, 0x43) inside the first transfer -> only 0x41 and 0x42 appear on the bus; ovf_o=1 and stays 1.
- Last-EXEC edge: with pending valid, an edge in the final EXEC cycle -> pending launches, new word queued, ovf_o=0; three EN pulses total.
- Reset mid-PULSE: rst_ni low -> en, data, rs, busy_o and ovf_o go to 0 asynchronously; with strobe held high through reset release, no transfer occurs until strobe goes 0->1.
- lcd_on_o: toggling bit31 with no strobe -> lcd_on_o follows after 1 cycle; en stays 0.
